wrr_sched: RTL and testbench
============================

WRR_SCHED -- requirements
Module: wrr_sched

Interface
REQ-001 Parameter DATA_W, default 10, SHALL set the FIFO word width; bits [DATA_W-1:DATA_W-2] SHALL be the destination field.
REQ-002 Parameter DEFAULT_WEIGHT, default 3'd1, SHALL set the reset value of every queue weight.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 empty_P0..empty_P3  input  1 each  input FIFO i empty.
REQ-006 in_FIFO_0..in_FIFO_3  input  DATA_W each  head word of input FIFO i (first-word-fall-through, valid when not empty).
REQ-007 pop_F0..pop_F3  output  1 each  pop input FIFO i this cycle.
REQ-008 almost_full_O0..almost_full_O3  input  1 each  output FIFO j can take at most one more word.
REQ-009 push_O0..push_O3  output  1 each  push output FIFO j this cycle.
REQ-010 out_FIFO_0..out_FIFO_3  output  DATA_W each  write data to output FIFO j.
REQ-011 cfg_we  input  1  weight write strobe.
REQ-012 cfg_weight  input  12  {w3,w2,w1,w0}, 3 bits per queue.
REQ-013 grant  output  2  queue currently holding the turn.
REQ-014 idle  output  1  high when no pop was issued in the previous cycle.

Function
REQ-015 Queue i SHALL be eligible when empty_Pi=0 and almost_full_O[d]=0, where d = in_FIFO_i destination field.
REQ-016 The FSM SHALL have two states: IDLE (no turn held) and ACTIVE (turn held by grant, credit counter cnt valid).
REQ-017 In ACTIVE, if grant is eligible and cnt < eff_weight[grant], the block SHALL pop grant and increment cnt.
REQ-018 Otherwise, the block SHALL search cyclically from grant+1 to grant (wrapping 3->0); on the first eligible j it SHALL pop j, set grant=j, cnt=1, stay ACTIVE.
REQ-019 If no queue is eligible, the block SHALL issue no pop, hold grant, clear cnt, and go to IDLE.
REQ-020 In IDLE, the block SHALL run the REQ-018 search from grant+1; if a queue is found it SHALL go to ACTIVE.
REQ-021 eff_weight SHALL equal the stored 3-bit weight, with 0 treated as 1 (range 1..7).
REQ-022 At most one pop_F SHALL be high per cycle.
REQ-023 The word popped at cycle t SHALL be registered and presented at t+1 on out_FIFO_d with push_Od=1 and all other push_O low (1-cycle latency).
REQ-024 out_FIFO_j SHALL hold its last value when push_Oj=0.
REQ-025 A cfg_we at cycle t SHALL update all four weights at t+1; an active turn SHALL end when cnt >= the new eff_weight.
REQ-026 A destination going almost_full mid-turn SHALL make that queue ineligible the same cycle; the in-flight word SHALL still be pushed.
REQ-027 idle SHALL be registered: idle at t+1 = no pop at t.

Reset
REQ-028 While reset=1 at a posedge: all pop_F and push_O=0, out_FIFO_0..3=0, grant=0, cnt=0, state=IDLE, idle=1, weights=DEFAULT_WEIGHT.
REQ-029 Reset asserted with a word registered but not yet pushed SHALL discard it (no push the following cycle).
REQ-030 After reset, the first search SHALL start from queue 1 (grant+1 with grant=0).

Structure
REQ-031 State encoding, DATA_W, DEST_MSB/LSB and DEFAULT_WEIGHT SHALL be defined in shared package rr_pkg.
REQ-032 The cyclic next-eligible search SHALL be a combinational sub-module rr_next_sel (inputs: eligible[3:0], start[1:0]; outputs: found, idx[1:0]).

Verification
REQ-033 Reset, all queues non-empty with destination 0, weights 1 -> pops in order P1,P2,P3,P0,P1; push_O0 every cycle from reset+2.
REQ-034 cfg_weight=12'o1113 (w0=3), all queues non-empty -> P0 popped 3 consecutive cycles, then P1, P2, P3 once each.
REQ-035 Only P2 non-empty, head dest=3, almost_full_O3=1 -> no pops, idle=1; drop almost_full_O3 -> pop_F2 next cycle, push_O3 one cycle later with the same word.
REQ-036 P0 word 10'h2A5 (dest 2) popped at t -> out_FIFO_2=10'h2A5, push_O2=1 only at t+1.
REQ-037 Reset asserted the cycle after a pop -> no push_O the next cycle, grant=0, idle=1.
REQ-038 w1=0, P1 only non-empty -> P1 popped every cycle (weight 0 treated as 1, turn re-granted to itself).

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the weighted round-robin scheduler: state encoding,
// word layout and weight defaults.
package rr_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam int DATA_W   = 10;
  localparam int DEST_MSB = DATA_W - 1;
  localparam int DEST_LSB = DATA_W - 2;

  localparam logic [2:0] DEFAULT_WEIGHT = 3'd1;

  // A stored weight of 0 still grants one word per turn.
  function automatic logic [2:0] eff_weight(input logic [2:0] w);
    return (w == 3'd0) ? 3'd1 : w;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Cyclic next-eligible search: checks start, start+1, ... start+3 (mod 4)
// and returns the first eligible index.
module rr_next_sel (
  input  logic [3:0] eligible,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    found = 1'b0;
    idx   = start;
    // Walk from the far end so the closest eligible queue is the last writer.
    for (int k = 3; k >= 0; k--) begin
      if (eligible[start + 2'(k)]) begin
        found = 1'b1;
        idx   = start + 2'(k);
      end
    end
  end

endmodule

// File: rtl/wrr_sched.sv
// Weighted round-robin scheduler moving words from four input FIFOs to four
// output FIFOs selected by each word's destination field.
module wrr_sched #(
  parameter int         DATA_W         = rr_pkg::DATA_W,
  parameter logic [2:0] DEFAULT_WEIGHT = rr_pkg::DEFAULT_WEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_P0,
  input  logic              empty_P1,
  input  logic              empty_P2,
  input  logic              empty_P3,
  input  logic [DATA_W-1:0] in_FIFO_0,
  input  logic [DATA_W-1:0] in_FIFO_1,
  input  logic [DATA_W-1:0] in_FIFO_2,
  input  logic [DATA_W-1:0] in_FIFO_3,
  output logic              pop_F0,
  output logic              pop_F1,
  output logic              pop_F2,
  output logic              pop_F3,
  input  logic              almost_full_O0,
  input  logic              almost_full_O1,
  input  logic              almost_full_O2,
  input  logic              almost_full_O3,
  output logic              push_O0,
  output logic              push_O1,
  output logic              push_O2,
  output logic              push_O3,
  output logic [DATA_W-1:0] out_FIFO_0,
  output logic [DATA_W-1:0] out_FIFO_1,
  output logic [DATA_W-1:0] out_FIFO_2,
  output logic [DATA_W-1:0] out_FIFO_3,
  input  logic              cfg_we,
  input  logic [11:0]       cfg_weight,
  output logic [1:0]        grant,
  output logic              idle
);

  // Destination field tracks the top two bits for any DATA_W.
  localparam int DMSB = rr_pkg::DEST_MSB - rr_pkg::DATA_W + DATA_W;
  localparam int DLSB = rr_pkg::DEST_LSB - rr_pkg::DATA_W + DATA_W;

  rr_pkg::state_t    r_state, w_state_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_weight [4];
  logic              r_idle;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_out [4];

  logic [DATA_W-1:0] w_head [4];
  logic [3:0]        w_empty, w_afull, w_elig, w_pop;
  logic [2:0]        w_eff;
  logic              w_found, w_pop_en;
  logic [1:0]        w_idx, w_pop_idx, w_pop_dest;
  logic [DATA_W-1:0] w_pop_word;

  assign w_head[0] = in_FIFO_0;
  assign w_head[1] = in_FIFO_1;
  assign w_head[2] = in_FIFO_2;
  assign w_head[3] = in_FIFO_3;
  assign w_empty   = {empty_P3, empty_P2, empty_P1, empty_P0};
  assign w_afull   = {almost_full_O3, almost_full_O2, almost_full_O1, almost_full_O0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = !w_empty[i] && !w_afull[w_head[i][DMSB:DLSB]];
    end
  end

  assign w_eff = rr_pkg::eff_weight(r_weight[r_grant]);

  rr_next_sel u_next_sel (
    .eligible (w_elig),
    .start    (r_grant + 2'd1),
    .found    (w_found),
    .idx      (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_pop_en    = 1'b0;
    w_pop_idx   = r_grant;
    if (r_state == rr_pkg::ST_ACTIVE && w_elig[r_grant] && r_cnt < w_eff) begin
      w_pop_en  = 1'b1;
      w_cnt_nxt = r_cnt + 3'd1;
    end else if (w_found) begin
      w_pop_en    = 1'b1;
      w_pop_idx   = w_idx;
      w_grant_nxt = w_idx;
      w_cnt_nxt   = 3'd1;
      w_state_nxt = rr_pkg::ST_ACTIVE;
    end else begin
      w_cnt_nxt   = 3'd0;
      w_state_nxt = rr_pkg::ST_IDLE;
    end
  end

  assign w_pop      = (w_pop_en && !reset) ? (4'b0001 << w_pop_idx) : 4'b0000;
  assign w_pop_word = w_head[w_pop_idx];
  assign w_pop_dest = w_pop_word[DMSB:DLSB];

  // NOTE: all state, including the output data registers, uses non-blocking
  // assignments and is cleared on reset so no stale word leaks out afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= rr_pkg::ST_IDLE;
      r_grant <= 2'd0;
      r_cnt   <= 3'd0;
      r_idle  <= 1'b1;
      r_push  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_weight[i] <= DEFAULT_WEIGHT;
        r_out[i]    <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= !w_pop_en;
      r_push  <= w_pop_en ? (4'b0001 << w_pop_dest) : 4'b0000;
      if (w_pop_en) r_out[w_pop_dest] <= w_pop_word;
      if (cfg_we) begin
        for (int i = 0; i < 4; i++) r_weight[i] <= cfg_weight[3*i +: 3];
      end
    end
  end

  assign {pop_F3, pop_F2, pop_F1, pop_F0}     = w_pop;
  assign {push_O3, push_O2, push_O1, push_O0} = r_push;
  assign out_FIFO_0 = r_out[0];
  assign out_FIFO_1 = r_out[1];
  assign out_FIFO_2 = r_out[2];
  assign out_FIFO_3 = r_out[3];
  assign grant      = r_grant;
  assign idle       = r_idle;

endmodule

// File: tb/tb_wrr_sched.sv
// Directed bench for wrr_sched: single-decision vectors from reset, then
// multi-cycle sequences for weights, back-pressure and reset corners.
module tb_wrr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  empty, afull;
  logic [9:0]  head [4];
  logic        cfg_we;
  logic [11:0] cfg_weight;
  wire  [3:0]  pop, push;
  wire  [9:0]  dout [4];
  wire  [1:0]  grant;
  wire         idle;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wrr_sched dut (
    .clk(clk), .reset(reset),
    .empty_P0(empty[0]), .empty_P1(empty[1]), .empty_P2(empty[2]), .empty_P3(empty[3]),
    .in_FIFO_0(head[0]), .in_FIFO_1(head[1]), .in_FIFO_2(head[2]), .in_FIFO_3(head[3]),
    .pop_F0(pop[0]), .pop_F1(pop[1]), .pop_F2(pop[2]), .pop_F3(pop[3]),
    .almost_full_O0(afull[0]), .almost_full_O1(afull[1]),
    .almost_full_O2(afull[2]), .almost_full_O3(afull[3]),
    .push_O0(push[0]), .push_O1(push[1]), .push_O2(push[2]), .push_O3(push[3]),
    .out_FIFO_0(dout[0]), .out_FIFO_1(dout[1]), .out_FIFO_2(dout[2]), .out_FIFO_3(dout[3]),
    .cfg_we(cfg_we), .cfg_weight(cfg_weight), .grant(grant), .idle(idle)
  );

  typedef struct {
    logic [3:0] empty;
    logic [3:0] afull;
    logic [9:0] h0, h1, h2, h3;
    logic [3:0] pop;
    logic [3:0] push;
    logic [1:0] grant;
    logic       idle;
    int         port;
    logic [9:0] data;
  } vec_t;

  vec_t vecs [7];
  int   exp_seq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over two edges with traffic present, checks the reset state,
  // then releases reset mid-cycle with every input FIFO empty.
  task automatic do_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_weight = '0; afull = '0; empty = '0;
    for (int i = 0; i < 4; i++) head[i] = '0;
    tick(); tick();
    check("rst_pop", 32'(pop), 0);
    check("rst_push", 32'(push), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_out", {dout[0][7:0], dout[1][7:0], dout[2][7:0], dout[3][7:0]}, 0);
    empty = 4'hF;
    reset = 1'b0;
  endtask

  // Runs the queued pop order with inputs held constant.
  task automatic check_seq(input string name);
    foreach (exp_seq[k]) begin
      #1;
      check($sformatf("%s_pop%0d", name, k), 32'(pop), 32'(4'b0001 << exp_seq[k]));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; empty = 4'hF; afull = '0; cfg_we = 1'b0; cfg_weight = '0;
    for (int i = 0; i < 4; i++) head[i] = '0;

    //          empty  afull  h0      h1      h2      h3      pop    push   gnt  idle port data
    vecs[0] = '{4'hF, 4'h0, 10'h000, 10'h000, 10'h000, 10'h000, 4'h0, 4'h0, 2'd0, 1'b1, 0, 10'h000};
    vecs[1] = '{4'h0, 4'h0, 10'h011, 10'h022, 10'h033, 10'h044, 4'h2, 4'h1, 2'd1, 1'b0, 0, 10'h022};
    vecs[2] = '{4'hE, 4'h0, 10'h2A5, 10'h000, 10'h000, 10'h000, 4'h1, 4'h4, 2'd0, 1'b0, 2, 10'h2A5};
    vecs[3] = '{4'h5, 4'h2, 10'h000, 10'h1AB, 10'h000, 10'h3C1, 4'h8, 4'h8, 2'd3, 1'b0, 3, 10'h3C1};
    vecs[4] = '{4'hB, 4'h8, 10'h000, 10'h000, 10'h3FF, 10'h000, 4'h0, 4'h0, 2'd0, 1'b1, 0, 10'h000};
    vecs[5] = '{4'h0, 4'hF, 10'h011, 10'h155, 10'h2A5, 10'h3C1, 4'h0, 4'h0, 2'd0, 1'b1, 0, 10'h000};
    vecs[6] = '{4'hA, 4'h0, 10'h0F0, 10'h000, 10'h155, 10'h000, 4'h4, 4'h2, 2'd2, 1'b0, 1, 10'h155};

    // Single decision from a fresh reset (search starts at queue 1).
    foreach (vecs[i]) begin
      do_reset();
      empty = vecs[i].empty; afull = vecs[i].afull;
      head[0] = vecs[i].h0; head[1] = vecs[i].h1; head[2] = vecs[i].h2; head[3] = vecs[i].h3;
      #1;
      check($sformatf("v%0d_pop", i), 32'(pop), 32'(vecs[i].pop));
      tick();
      empty = 4'hF;
      check($sformatf("v%0d_push", i), 32'(push), 32'(vecs[i].push));
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].idle));
      if (vecs[i].push != 4'h0)
        check($sformatf("v%0d_data", i), 32'(dout[vecs[i].port]), 32'(vecs[i].data));
    end

    // Equal weights, all destination 0: P1,P2,P3,P0,P1 with a push every cycle.
    begin
      int order [5] = '{1, 2, 3, 0, 1};
      do_reset();
      head[0] = 10'h011; head[1] = 10'h022; head[2] = 10'h033; head[3] = 10'h044;
      empty = 4'h0;
      for (int k = 0; k < 5; k++) begin
        #1;
        check($sformatf("rr_pop%0d", k), 32'(pop), 32'(4'b0001 << order[k]));
        tick();
        check($sformatf("rr_push%0d", k), 32'(push), 1);
        check($sformatf("rr_data%0d", k), 32'(dout[0]), 32'(10'h011 * (order[k] + 1)));
      end
    end

    // w0 = 3: P0 holds the turn for three pops.
    do_reset();
    cfg_we = 1'b1; cfg_weight = 12'o1113;
    tick();
    cfg_we = 1'b0;
    empty = 4'h0;
    exp_seq = '{1, 2, 3, 0, 0, 0, 1, 2, 3};
    check_seq("w3");

    // Back-pressure on the only candidate's destination, then release.
    do_reset();
    empty = 4'hB; afull = 4'h8; head[2] = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_pop%0d", k), 32'(pop), 0);
      tick();
      check($sformatf("bp_idle%0d", k), 32'(idle), 1);
    end
    afull = 4'h0;
    #1;
    check("bp_release_pop", 32'(pop), 32'h4);
    tick();
    empty = 4'hF;
    check("bp_release_push", 32'(push), 32'h8);
    check("bp_release_data", 32'(dout[3]), 32'h3FF);

    // Reset in the cycle after a pop drops the pending push.
    do_reset();
    empty = 4'h0;
    #1;
    check("rstpop_pop", 32'(pop), 32'h2);
    tick();
    reset = 1'b1;
    #1;
    check("rstpop_gated", 32'(pop), 0);
    tick();
    check("rstpop_push", 32'(push), 0);
    check("rstpop_grant", 32'(grant), 0);
    check("rstpop_idle", 32'(idle), 1);
    reset = 1'b0;
    empty = 4'hF;

    // Weight 0 acts as 1; a lone queue is re-granted to itself every cycle.
    do_reset();
    cfg_we = 1'b1; cfg_weight = {3'd1, 3'd1, 3'd0, 3'd1};
    tick();
    cfg_we = 1'b0;
    empty = 4'hD; head[1] = 10'h0AA;
    exp_seq = '{1, 1, 1, 1, 1};
    check_seq("w0");
    check("w0_grant", 32'(grant), 1);
    check("w0_push", 32'(push), 1);

    // Weight lowered mid-turn: P0 turn ends once cnt reaches the new weight.
    do_reset();
    cfg_we = 1'b1; cfg_weight = {3'd1, 3'd1, 3'd1, 3'd7};
    tick();
    cfg_we = 1'b0;
    empty = 4'hC;
    #1; check("cfg_pop0", 32'(pop), 32'h2); tick();
    #1; check("cfg_pop1", 32'(pop), 32'h1); tick();
    #1; check("cfg_pop2", 32'(pop), 32'h1);
    cfg_we = 1'b1; cfg_weight = {3'd1, 3'd1, 3'd1, 3'd2};
    tick();
    cfg_we = 1'b0;
    #1; check("cfg_pop3", 32'(pop), 32'h2); tick();
    empty = 4'hF;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
